float_multiplier_pipelined: RTL and testbench



---
 rtl/float_multiplier_pipelined_pkg.sv | 72 +++++++
 rtl/float_round_rne.sv | 56 +++++
 rtl/float_multiplier_pipelined.sv | 212 +++++++++++++++++++++
 tb/tb_float_multiplier_pipelined.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_multiplier_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Package     : float_pkg
// Description : Shared types and helpers for the pipelined float multiplier:
//               operand classes, stage-control structs, special-value packers.
// Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } float_class_t;

    typedef enum logic [1:0] {
        SPEC_NONE = 2'd0,
        SPEC_NAN  = 2'd1,
        SPEC_INF  = 2'd2,
        SPEC_ZERO = 2'd3
    } special_t;

    // Control travelling alongside the datapath through stages 1 and 2
    typedef struct packed {
        logic     sign;
        special_t special;
        logic     invalid;
    } stage_ctrl_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid;
    } flags_t;

    localparam int c_MAX_FLOAT = 64;

    function automatic float_class_t classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) return ZERO;
        if (exp_ones) begin
            if (frac_zero) return INF;
            return NAN;
        end
        return NORMAL;
    endfunction

    // Packers return the value right-aligned in c_MAX_FLOAT bits; callers truncate
    function automatic logic [c_MAX_FLOAT-1:0] canonical_nan(input int exp_size,
                                                             input int man_size);
        return (((c_MAX_FLOAT'(1) << exp_size) - c_MAX_FLOAT'(1)) << man_size)
             | (c_MAX_FLOAT'(1) << (man_size - 1));
    endfunction

    function automatic logic [c_MAX_FLOAT-1:0] signed_inf(input logic sign,
                                                          input int   exp_size,
                                                          input int   man_size);
        return (c_MAX_FLOAT'(sign) << (exp_size + man_size))
             | (((c_MAX_FLOAT'(1) << exp_size) - c_MAX_FLOAT'(1)) << man_size);
    endfunction

    function automatic logic [c_MAX_FLOAT-1:0] signed_zero(input logic sign,
                                                           input int   exp_size,
                                                           input int   man_size);
        return c_MAX_FLOAT'(sign) << (exp_size + man_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : float_round_rne
// Description : Combinational round-to-nearest-even plus post-rounding range
//               check; produces packed exponent/fraction and exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module float_round_rne #(
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23
) (
    input  logic [MANTISSA_SIZE:0]          i_sig,
    input  logic                            i_guard,
    input  logic                            i_sticky,
    input  logic signed [EXPONENT_SIZE+1:0] i_exp,
    output logic [EXPONENT_SIZE-1:0]        o_exp,
    output logic [MANTISSA_SIZE-1:0]        o_frac,
    output logic                            o_overflow,
    output logic                            o_underflow,
    output logic                            o_inexact
);
    localparam int c_EW = EXPONENT_SIZE + 2;
    localparam logic signed [c_EW-1:0] c_EXP_MAX  = c_EW'((1 << EXPONENT_SIZE) - 1);
    localparam logic signed [c_EW-1:0] c_EXP_ZERO = '0;

    logic                   w_round_up;
    logic [MANTISSA_SIZE+1:0] w_sum;
    logic signed [c_EW-1:0] w_exp_final;

    always_comb begin
        w_round_up  = i_guard & (i_sticky | i_sig[0]);
        w_sum       = {1'b0, i_sig} + {{(MANTISSA_SIZE+1){1'b0}}, w_round_up};
        w_exp_final = i_exp + $signed({{(c_EW-1){1'b0}}, w_sum[MANTISSA_SIZE+1]});

        o_exp       = '0;
        o_frac      = '0;
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_inexact   = i_guard | i_sticky;

        if (w_exp_final >= c_EXP_MAX) begin
            o_exp      = '1;
            o_overflow = 1'b1;
            o_inexact  = 1'b1;
        end else if (w_exp_final <= c_EXP_ZERO) begin
            o_underflow = 1'b1;
            o_inexact   = 1'b1;
        end else begin
            o_exp  = w_exp_final[EXPONENT_SIZE-1:0];
            // On carry-out the sum is 10...0, so the low bits are already the zero fraction
            o_frac = w_sum[MANTISSA_SIZE-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/float_multiplier_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : float_multiplier_pipelined
// Description : Three-stage IEEE-754-style float multiplier with RNE rounding,
//               special-value handling and per-stage valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module float_multiplier_pipelined
    import float_pkg::*;
#(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact,
    output logic                  invalid
);
    localparam int c_EW     = EXPONENT_SIZE + 2;
    localparam int c_SW     = MANTISSA_SIZE + 1;
    localparam int c_PW     = 2 * c_SW;
    localparam int c_NSTAGE = 3;
    localparam logic signed [c_EW-1:0] c_BIAS = c_EW'(BIAS);

    // ------------------------------------------------------------------
    // Valid/ready control, one identical slice per stage
    // ------------------------------------------------------------------
    logic [c_NSTAGE:1] r_valid;
    logic [c_NSTAGE:1] w_ready;
    logic [c_NSTAGE:1] w_up_valid;
    logic [c_NSTAGE:1] w_load;
    logic [c_NSTAGE:1] w_valid_nxt;

    assign w_up_valid = {r_valid[c_NSTAGE-1:1], in_valid};

    generate
        for (genvar k = 1; k <= c_NSTAGE; k++) begin : g_stage
            // ready_k = ~v_k | ready_{k+1} unrolled, so no bit depends on its own vector
            assign w_ready[k]     = ~(&r_valid[c_NSTAGE:k]) | out_ready;
            assign w_load[k]      = w_ready[k] & w_up_valid[k];
            assign w_valid_nxt[k] = w_ready[k] ? w_up_valid[k] : r_valid[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) r_valid <= '0;
        else       r_valid <= w_valid_nxt;
    end

    assign in_ready  = w_ready[1];
    assign out_valid = r_valid[c_NSTAGE];

    // ------------------------------------------------------------------
    // Stage 1: classify, exponent sum, special-case resolution
    // ------------------------------------------------------------------
    logic [EXPONENT_SIZE-1:0] w_ea, w_eb;
    logic [MANTISSA_SIZE-1:0] w_fa, w_fb;
    float_class_t             w_ca, w_cb;
    stage_ctrl_t              w_ctrl0;
    logic signed [c_EW-1:0]   w_exp0;

    assign w_ea = a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign w_eb = b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign w_fa = a[MANTISSA_SIZE-1:0];
    assign w_fb = b[MANTISSA_SIZE-1:0];
    assign w_ca = classify(w_ea == '0, w_ea == '1, w_fa == '0);
    assign w_cb = classify(w_eb == '0, w_eb == '1, w_fb == '0);
    assign w_exp0 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS;

    always_comb begin
        w_ctrl0.sign    = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
        w_ctrl0.special = SPEC_NONE;
        w_ctrl0.invalid = 1'b0;
        if (w_ca == NAN || w_cb == NAN) begin
            w_ctrl0.special = SPEC_NAN;
        end else if ((w_ca == INF && w_cb == ZERO) || (w_ca == ZERO && w_cb == INF)) begin
            w_ctrl0.special = SPEC_NAN;
            w_ctrl0.invalid = 1'b1;
        end else if (w_ca == INF || w_cb == INF) begin
            w_ctrl0.special = SPEC_INF;
        end else if (w_ca == ZERO || w_cb == ZERO) begin
            w_ctrl0.special = SPEC_ZERO;
        end
    end

    stage_ctrl_t            r_ctrl1;
    logic signed [c_EW-1:0] r_exp1;
    logic [c_SW-1:0]        r_sig_a1, r_sig_b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl1  <= '0;
            r_exp1   <= '0;
            r_sig_a1 <= '0;
            r_sig_b1 <= '0;
        end else if (w_load[1]) begin
            r_ctrl1  <= w_ctrl0;
            r_exp1   <= w_exp0;
            r_sig_a1 <= {1'b1, w_fa};
            r_sig_b1 <= {1'b1, w_fb};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand multiply
    // ------------------------------------------------------------------
    stage_ctrl_t            r_ctrl2;
    logic signed [c_EW-1:0] r_exp2;
    logic [c_PW-1:0]        r_prod2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl2 <= '0;
            r_exp2  <= '0;
            r_prod2 <= '0;
        end else if (w_load[2]) begin
            r_ctrl2 <= r_ctrl1;
            r_exp2  <= r_exp1;
            r_prod2 <= c_PW'(r_sig_a1) * c_PW'(r_sig_b1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, range check, pack
    // ------------------------------------------------------------------
    logic                     w_msb;
    logic [c_PW-1:0]          w_prod_n;
    logic signed [c_EW-1:0]   w_exp_n;
    logic [c_SW-1:0]          w_sig3;
    logic                     w_guard3, w_sticky3;
    logic [EXPONENT_SIZE-1:0] w_exp_r;
    logic [MANTISSA_SIZE-1:0] w_frac_r;
    logic                     w_ovf, w_unf, w_inx;
    logic [FLOAT_SIZE-1:0]    w_res;
    flags_t                   w_flags;

    // Product lies in [1,4); align so the leading one sits at the top bit
    assign w_msb     = r_prod2[c_PW-1];
    assign w_prod_n  = w_msb ? r_prod2 : {r_prod2[c_PW-2:0], 1'b0};
    assign w_exp_n   = r_exp2 + $signed({{(c_EW-1){1'b0}}, w_msb});
    assign w_sig3    = w_prod_n[c_PW-1 -: c_SW];
    assign w_guard3  = w_prod_n[MANTISSA_SIZE];
    assign w_sticky3 = |w_prod_n[MANTISSA_SIZE-1:0];

    float_round_rne #(
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .MANTISSA_SIZE (MANTISSA_SIZE)
    ) u_round (
        .i_sig       (w_sig3),
        .i_guard     (w_guard3),
        .i_sticky    (w_sticky3),
        .i_exp       (w_exp_n),
        .o_exp       (w_exp_r),
        .o_frac      (w_frac_r),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf),
        .o_inexact   (w_inx)
    );

    always_comb begin
        w_res   = {r_ctrl2.sign, w_exp_r, w_frac_r};
        w_flags = '{overflow: w_ovf, underflow: w_unf, inexact: w_inx, invalid: 1'b0};
        case (r_ctrl2.special)
            SPEC_NAN: begin
                w_res   = FLOAT_SIZE'(canonical_nan(EXPONENT_SIZE, MANTISSA_SIZE));
                w_flags = '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0,
                            invalid: r_ctrl2.invalid};
            end
            SPEC_INF: begin
                w_res   = FLOAT_SIZE'(signed_inf(r_ctrl2.sign, EXPONENT_SIZE, MANTISSA_SIZE));
                w_flags = '0;
            end
            SPEC_ZERO: begin
                w_res   = FLOAT_SIZE'(signed_zero(r_ctrl2.sign, EXPONENT_SIZE, MANTISSA_SIZE));
                w_flags = '0;
            end
            default: ;
        endcase
    end

    logic [FLOAT_SIZE-1:0] r_out;
    flags_t                r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_flags <= '0;
        end else if (w_load[3]) begin
            r_out   <= w_res;
            r_flags <= w_flags;
        end
    end

    assign out       = r_out;
    assign overflow  = r_flags.overflow;
    assign underflow = r_flags.underflow;
    assign inexact   = r_flags.inexact;
    assign invalid   = r_flags.invalid;

endmodule
`default_nettype wire

// File: tb/tb_float_multiplier_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_multiplier_pipelined
// Description : Self-checking bench: directed vectors, backpressure, reset
//               mid-stream and a random stream against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_float_multiplier_pipelined;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic        overflow, underflow, inexact, invalid;
    logic [31:0] a, b, out;
    logic [3:0]  flags;

    assign flags = {overflow, underflow, inexact, invalid};

    always #5 clk = ~clk;

    float_multiplier_pipelined #(
        .FLOAT_SIZE (32), .EXPONENT_SIZE (8), .MANTISSA_SIZE (23), .BIAS (127)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready), .a (a), .b (b),
        .out_valid (out_valid), .out_ready (out_ready), .out (out),
        .overflow (overflow), .underflow (underflow), .inexact (inexact), .invalid (invalid)
    );

    typedef struct {
        logic [31:0] v;
        logic [3:0]  f;   // {overflow, underflow, inexact, invalid}
    } res_t;

    res_t        sb_q[$];
    logic [31:0] op_a[$], op_b[$];
    int          n_checks = 0, n_errors = 0, n_results = 0;

    // Directed vectors with hand-computed results
    localparam int NV = 11;
    logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                             32'h00800000, 32'h7F800000, 32'hFF800000, 32'h80000000,
                             32'h7FC00001, 32'h00000001, 32'h80400000};
    logic [31:0] vb [NV] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h40000000,
                             32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F800000,
                             32'h3F800000, 32'h7F800000, 32'h3F800000};
    logic [31:0] ve [NV] = '{32'h40400000, 32'h3FC00002, 32'h3F800002, 32'h7F800000,
                             32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                             32'h7FC00000, 32'h7FC00000, 32'h80000000};
    logic [3:0]  vf [NV] = '{4'b0000, 4'b0010, 4'b0010, 4'b1010,
                             4'b0110, 4'b0001, 4'b0000, 4'b0000,
                             4'b0000, 4'b0001, 4'b0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact integer product, then rounded by remainder against the half-ulp
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        res_t r;
        int ex, ey, e, drop;
        logic s, zx, zy, ix, iy, nx, ny;
        longint p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        r.f = 4'b0000;
        r.v = 32'h0;
        if (nx || ny) begin r.v = 32'h7FC00000; return r; end
        if ((ix && zy) || (zx && iy)) begin r.v = 32'h7FC00000; r.f = 4'b0001; return r; end
        if (ix || iy) begin r.v = {s, 31'h7F800000}; return r; end
        if (zx || zy) begin r.v = {s, 31'h0}; return r; end
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        drop = 0;
        while ((p >> drop) >= 64'd16777216) drop++;
        q    = p >> drop;
        rem  = p - (q << drop);
        half = longint'(1) << (drop - 1);
        if (rem != 0) r.f[1] = 1'b1;
        if (rem > half || (rem == half && q[0])) q++;
        e = ex + ey - 127 + (drop - 23);
        if (q == 64'd16777216) begin q = q >> 1; e++; end
        if (e >= 255) begin
            r.v = {s, 31'h7F800000}; r.f = 4'b1010;
        end else if (e <= 0) begin
            r.v = {s, 31'h0}; r.f = 4'b0110;
        end else begin
            r.v = {s, e[7:0], q[22:0]};
        end
        return r;
    endfunction

    // Scoreboard/compare process; runs on the falling edge
    initial begin
        logic        prev_stall;
        logic [35:0] prev_val;
        res_t        e;
        prev_stall = 1'b0;
        prev_val   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 64'(out_valid), 64'd1);
                    check("stall_hold_data", 64'({out, flags}), 64'(prev_val));
                end
                if (out_valid && sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_result: got out_valid with %h, expected no pending result", out);
                end else if (out_valid && out_ready) begin
                    e = sb_q.pop_front();
                    check("sb_out", 64'(out), 64'(e.v));
                    check("sb_flags", 64'(flags), 64'(e.f));
                    n_results++;
                end
                if (in_valid && in_ready) sb_q.push_back(model(a, b));
                prev_stall = out_valid && !out_ready;
                prev_val   = {out, flags};
            end
        end
    end

    // Single operation with idle pipeline: latency and literal result
    task automatic run_single(input int i);
        int n;
        @(posedge clk); #1;
        a = va[i]; b = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
        #1 check($sformatf("in_ready_idle%0d", i), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency%0d", i), 64'(n), 64'd3);
        check($sformatf("dir_out%0d", i), 64'(out), 64'(ve[i]));
        check($sformatf("dir_flags%0d", i), 64'(flags), 64'(vf[i]));
    endtask

    // Stream op_a/op_b; out_ready held low for 'stall' cycles, then high or random
    task automatic drive_ops(input int stall, input bit rnd_ready);
        int i, cyc;
        logic acc;
        bit checked;
        i = 0; cyc = 0; checked = 0;
        while (i < op_a.size() && cyc < 2000) begin
            out_ready = (cyc >= stall) && (!rnd_ready || $urandom_range(0, 3) != 0);
            a = op_a[i]; b = op_b[i]; in_valid = 1'b1;
            #1 acc = in_ready;
            if (stall > 3 && i == 3 && cyc < stall && !checked) begin
                check("in_ready_full", 64'(in_ready), 64'd0);
                checked = 1;
            end
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < op_a.size()) begin
            n_checks++; n_errors++;
            $display("FAIL drive_timeout: accepted %0d of %0d operations", i, op_a.size());
        end
    endtask

    task automatic wait_drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_float();
        int sel, ex;
        sel = $urandom_range(0, 11);
        case (sel)
            0:       ex = 0;
            1, 2:    ex = 255;
            3:       ex = $urandom_range(1, 12);
            4:       ex = $urandom_range(240, 254);
            default: ex = $urandom_range(90, 165);
        endcase
        if (sel == 1) return {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
        return {1'($urandom_range(0, 1)), ex[7:0], 23'($urandom)};
    endfunction

    initial begin
        int n0;
        res_t m;
        // Reset held with in_valid high must accept nothing
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 32'h3FC00000; b = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        in_valid = 1'b0; reset = 1'b0;
        #1 check("in_ready_after_reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            m = model(va[i], vb[i]);
            check($sformatf("model_pin%0d", i), 64'({m.v, m.f}), 64'({ve[i], vf[i]}));
        end

        for (int i = 0; i < NV; i++) run_single(i);

        // Back-to-back directed stream
        @(posedge clk); #1;
        op_a.delete(); op_b.delete();
        for (int i = 0; i < NV; i++) begin op_a.push_back(va[i]); op_b.push_back(vb[i]); end
        drive_ops(0, 1'b0);
        wait_drain();

        // Backpressure: 5 inputs with output stalled 6 cycles
        n0 = n_results;
        op_a.delete(); op_b.delete();
        for (int i = 0; i < 5; i++) begin op_a.push_back(va[i + 1]); op_b.push_back(vb[i]); end
        drive_ops(6, 1'b0);
        wait_drain();
        check("bp_result_count", 64'(n_results - n0), 64'd5);

        // Reset with 3 operations in flight
        op_a.delete(); op_b.delete();
        for (int i = 0; i < 3; i++) begin op_a.push_back(va[i]); op_b.push_back(vb[i]); end
        drive_ops(20, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        #1 check("midreset_in_ready", 64'(in_ready), 64'd1);
        n0 = n_results;
        repeat (8) @(posedge clk);
        #1 check("midreset_no_ghost", 64'(n_results - n0), 64'd0);
        run_single(0);
        wait_drain();

        // Random stream with random backpressure
        op_a.delete(); op_b.delete();
        for (int i = 0; i < 300; i++) begin op_a.push_back(rand_float()); op_b.push_back(rand_float()); end
        n0 = n_results;
        drive_ops(0, 1'b1);
        wait_drain();
        check("rand_result_count", 64'(n_results - n0), 64'd300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
